adc_spi_sampler: RTL and testbench
==================================

// Module: adc_spi_sampler
// PURPOSE
//   SPI master front end for the 12-bit serial ADC on the receive path. Drives CS and SCLK,
//   shifts in one 16-bit frame per conversion (4 leading zeros + 12 data bits, MSB first),
//   and presents Dato/Zeros with a one-cycle Listo strobe. Listo is the load enable of the
//   downstream holding register that feeds the seven-segment display check.
// PARAMETERS
//   CLK_DIV   4    SCLK half-period in clk cycles (SCLK = clk/(2*CLK_DIV)); legal range >= 2
//   NBITS     16   bits per frame (SCLK rising edges while CS low)
//   DATA_W    12   data bits; frame LSBs. Zero-field width = NBITS-DATA_W
//   GAP_CYC   20   clk cycles CS is held high between frames (quiet time); legal range >= 1
// PORTS
//   clk      in   1       system clock, all logic on rising edge
//   rst      in   1       asynchronous, active-low reset
//   en       in   1       1 = run conversions continuously; sampled only in IDLE
//   data_in  in   1       ADC serial data (MISO)
//   sclk     out  1       serial clock to ADC, idles high
//   CS       out  1       chip select to ADC, active low
//   Dato     out  DATA_W  last captured data field, frame[DATA_W-1:0]
//   Zeros    out  4       last captured leading field, frame[NBITS-1:DATA_W]
//   Listo    out  1       one-cycle strobe: Dato/Zeros updated this cycle
//   busy     out  1       1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, CS=1, sclk=1, Dato=0, Zeros=0, Listo=0, busy=0,
//     shift register, bit counter and divider counter = 0. Reset mid-frame aborts the frame;
//     no partial data ever reaches Dato/Zeros.
//   All outputs registered. FSM: IDLE -> SETUP -> SHIFT -> DONE -> GAP -> IDLE.
//   IDLE:  CS=1, sclk=1. If en=1 -> SETUP next cycle, CS goes low on that same edge.
//   SETUP: CS=0, sclk=1 for CLK_DIV cycles (CS-to-first-SCLK-fall setup), then -> SHIFT.
//   SHIFT: divider counts 0..CLK_DIV-1; at terminal count sclk toggles. First toggle is
//     1->0. On each 0->1 toggle, data_in (value at that clk edge) shifts in at LSB,
//     shift <= {shift[NBITS-2:0], data_in}; bit counter increments.
//     After NBITS-th rising edge -> DONE (sclk remains 1).
//   DONE (1 cycle): CS=1, Dato<=shift[DATA_W-1:0], Zeros<=shift[NBITS-1:DATA_W], Listo=1.
//   GAP: CS=1, sclk=1 for GAP_CYC cycles, then -> IDLE. Listo=0 outside DONE.
//   Timing (defaults): CS low for CLK_DIV+2*NBITS*CLK_DIV = 132 cycles; Listo one cycle after
//     CS rises; frame-to-frame period = 1+132+1+20 = 154 cycles with en held high.
//   en deassert mid-frame: current frame completes incl. DONE/GAP; no new frame starts.
//   Zeros is reported as received (no check); nonzero value flags link error downstream.
//   Dato/Zeros hold last value until next DONE; never change while Listo=0.
//   Counters never wrap: bit counter width ceil(log2(NBITS+1)), cleared in IDLE/SETUP.
// TESTING
//   1 Reset: rst=0 mid-SHIFT -> same cycle async CS=1,sclk=1,Dato=0,Zeros=0,Listo=0,busy=0.
//   2 Single frame: en=1, ADC model drives 16'h0AC3 on SCLK falls -> exactly 16 sclk falls
//     while CS=0, CS low 132 cycles, Listo pulse 1 cycle, Dato=12'hAC3, Zeros=4'h0.
//   3 Zero-field report: model drives 16'h5FFF -> Dato=12'hFFF, Zeros=4'h5.
//   4 Back-to-back: en held 1, frames 16'h0001 then 16'h0800 -> Dato 12'h001 then 12'h800,
//     Listo strobes 154 cycles apart, CS high >= GAP_CYC+1 cycles between frames.
//   5 en drop: en=0 at bit 7 of frame -> frame completes, Listo once, then IDLE, CS stays 1.
//   6 Abort/restart: rst pulse at bit 10, release with en=1 -> next full frame captured
//     correctly; Dato shows no partial value at any time.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: SPI master front end for a 12-bit serial ADC.
// Shifts in one NBITS frame per conversion and strobes Listo on update.
module adc_spi_sampler #(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = 16,
  parameter int DATA_W  = 12,
  parameter int GAP_CYC = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    data_in,
  output logic                    sclk,
  output logic                    CS,
  output logic [DATA_W-1:0]       Dato,
  output logic [NBITS-DATA_W-1:0] Zeros,
  output logic                    Listo,
  output logic                    busy
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(NBITS+1);
  localparam int GAP_W = $clog2(GAP_CYC+1);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS-1);
  localparam logic [GAP_W-1:0] GAP_TC   = GAP_W'(GAP_CYC-1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, DONE, GAP
  } state_t;

  state_t                  r_state, w_nxt;
  logic [DIV_W-1:0]        r_div, w_div_nxt;
  logic [BIT_W-1:0]        r_bit, w_bit_nxt;
  logic [GAP_W-1:0]        r_gap, w_gap_nxt;
  logic [NBITS-1:0]        r_shift, w_shift_nxt;
  logic [DATA_W-1:0]       r_dato, w_dato_nxt;
  logic [NBITS-DATA_W-1:0] r_zeros, w_zeros_nxt;
  logic                    r_sclk, w_sclk_nxt;
  logic                    r_cs, w_cs_nxt;
  logic                    r_listo, w_listo_nxt;
  logic                    r_busy, w_busy_nxt;

  always_comb begin
    w_nxt       = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_shift_nxt = r_shift;
    w_dato_nxt  = r_dato;
    w_zeros_nxt = r_zeros;
    w_sclk_nxt  = 1'b1;
    w_listo_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_div_nxt = '0;
        w_bit_nxt = '0;
        w_gap_nxt = '0;
        if (en) w_nxt = SETUP;
      end
      SETUP: begin
        w_bit_nxt = '0;
        if (r_div == DIV_TC) begin
          w_div_nxt = '0;
          w_nxt     = SHIFT;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      SHIFT: begin
        w_sclk_nxt = r_sclk;
        if (r_div == DIV_TC) begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          // data is taken on the SCLK rising toggle
          if (!r_sclk) begin
            w_shift_nxt = {r_shift[NBITS-2:0], data_in};
            w_bit_nxt   = r_bit + 1'b1;
            if (r_bit == BIT_LAST) w_nxt = DONE;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      DONE: begin
        w_dato_nxt  = r_shift[DATA_W-1:0];
        w_zeros_nxt = r_shift[NBITS-1:DATA_W];
        w_listo_nxt = 1'b1;
        w_gap_nxt   = '0;
        w_nxt       = GAP;
      end
      GAP: begin
        if (r_gap == GAP_TC) begin
          w_gap_nxt = '0;
          w_nxt     = IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
    w_cs_nxt   = !(w_nxt == SETUP || w_nxt == SHIFT);
    w_busy_nxt = (w_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_shift <= '0;
      r_dato  <= '0;
      r_zeros <= '0;
      r_sclk  <= 1'b1;
      r_cs    <= 1'b1;
      r_listo <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_gap   <= w_gap_nxt;
      r_shift <= w_shift_nxt;
      r_dato  <= w_dato_nxt;
      r_zeros <= w_zeros_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs    <= w_cs_nxt;
      r_listo <= w_listo_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign sclk  = r_sclk;
  assign CS    = r_cs;
  assign Dato  = r_dato;
  assign Zeros = r_zeros;
  assign Listo = r_listo;
  assign busy  = r_busy;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: directed bench for adc_spi_sampler.
// Serial ADC model drives frames on SCLK falls.
module tb_adc_spi_sampler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        data_in = 1'b0;
  logic        sclk, CS, Listo, busy;
  logic [11:0] Dato;
  logic [3:0]  Zeros;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_spi_sampler dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .sclk(sclk), .CS(CS), .Dato(Dato), .Zeros(Zeros),
    .Listo(Listo), .busy(busy)
  );

  logic [15:0] next_frame = '0;
  logic [15:0] cur = '0;
  int idx = 15;
  int falls = 0;

  always @(negedge CS) begin
    cur = next_frame;
    idx = 15;
    falls = 0;
  end

  always @(negedge sclk) begin
    if (!CS) begin
      falls++;
      data_in = cur[idx[3:0]];
      if (idx > 0) idx--;
    end
  end

  int cyc = 0, low_run = 0, high_run = 0;
  int low_len = 0, high_len = 0, rise_cyc = 0;
  int cs_falls = 0, listo_cnt = 0, listo_cyc = 0;
  int listo_lag = 0, dato_bad = 0;
  logic prev_cs = 1'b1, prev_rst = 1'b0;
  logic [11:0] prev_dato = '0;
  logic [3:0]  prev_zeros = '0;

  always @(negedge clk) begin
    cyc++;
    if (CS != prev_cs) begin
      if (CS) begin
        low_len = low_run;
        high_run = 0;
        rise_cyc = cyc;
      end else begin
        high_len = high_run;
        low_run = 0;
        cs_falls++;
      end
    end
    if (CS) high_run++;
    else low_run++;
    if (Listo) begin
      listo_cnt++;
      listo_lag = cyc - rise_cyc;
      listo_cyc = cyc;
    end
    if (rst && prev_rst && !Listo &&
        (Dato != prev_dato || Zeros != prev_zeros))
      dato_bad++;
    prev_cs = CS;
    prev_rst = rst;
    prev_dato = Dato;
    prev_zeros = Zeros;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_listo(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = Listo;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_falls(input string tag, input int n,
                            input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = (falls == n) && !CS;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  int c1, c2, base_l, base_f;

  initial begin
    repeat (3) tick();
    chk("rst_cs", 32'(CS), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_dato", 32'(Dato), 32'd0);
    chk("rst_zeros", 32'(Zeros), 32'd0);
    chk("rst_listo", 32'(Listo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_cs", 32'(CS), 32'd1);

    next_frame = 16'h0AC3;
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_listo("t2_listo", 300);
    chk("t2_dato", 32'(Dato), 32'hAC3);
    chk("t2_zeros", 32'(Zeros), 32'h0);
    chk("t2_falls", falls, 16);
    chk("t2_cs_low", low_len, 132);
    chk("t2_lag", listo_lag, 1);
    tick();
    chk("t2_listo_w", 32'(Listo), 32'd0);
    repeat (30) tick();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_cs_idle", 32'(CS), 32'd1);

    next_frame = 16'h5FFF;
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_listo("t3_listo", 300);
    chk("t3_dato", 32'(Dato), 32'hFFF);
    chk("t3_zeros", 32'(Zeros), 32'h5);
    repeat (30) tick();

    next_frame = 16'h0001;
    en = 1'b1;
    wait_listo("t4_l1", 300);
    c1 = listo_cyc;
    chk("t4_dato1", 32'(Dato), 32'h001);
    next_frame = 16'h0800;
    tick();
    wait_listo("t4_l2", 300);
    c2 = listo_cyc;
    en = 1'b0;
    chk("t4_dato2", 32'(Dato), 32'h800);
    chk("t4_period", c2 - c1, 154);
    chk("t4_cs_gap", 32'(high_len >= 21), 32'd1);
    repeat (40) tick();
    chk("t4_idle", 32'(busy), 32'd0);

    base_l = listo_cnt;
    base_f = cs_falls;
    next_frame = 16'h0123;
    en = 1'b1;
    wait_falls("t5_bit7", 7, 300);
    en = 1'b0;
    wait_listo("t5_listo", 300);
    chk("t5_dato", 32'(Dato), 32'h123);
    repeat (200) tick();
    chk("t5_listo_n", listo_cnt - base_l, 1);
    chk("t5_frames", cs_falls - base_f, 1);
    chk("t5_cs", 32'(CS), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);

    next_frame = 16'h0F0F;
    en = 1'b1;
    wait_falls("t6_bit10", 10, 300);
    rst = 1'b0;
    #1;
    chk("t6_cs", 32'(CS), 32'd1);
    chk("t6_sclk", 32'(sclk), 32'd1);
    chk("t6_dato", 32'(Dato), 32'd0);
    chk("t6_zeros", 32'(Zeros), 32'd0);
    chk("t6_listo", 32'(Listo), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    next_frame = 16'h0E5A;
    tick();
    rst = 1'b1;
    tick();
    en = 1'b0;
    wait_listo("t6_relisto", 300);
    chk("t6_redato", 32'(Dato), 32'hE5A);
    chk("t6_rezeros", 32'(Zeros), 32'h0);
    chk("t6_cs_low", low_len, 132);
    repeat (30) tick();
    chk("dato_stable", dato_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
